issue_unit: RTL and testbench

ISSUE_UNIT -- requirements
Module: issue_unit

---
 rtl/issue_unit_pkg.sv | 15 +
 rtl/issue_unit_rr_picker.sv | 38 +++
 rtl/issue_unit.sv | 122 ++++++++++++
 tb/tb_issue_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_unit_pkg.sv
// Shared GPU parameter package.
// Holds the default warp count, warp-ID width and greedy burst limit used by
// the issue stage, plus a helper that sizes the greedy burst counter.
package issue_unit_pkg;

   localparam int unsigned GPU_NUM_WARPS    = 8;
   localparam int unsigned GPU_LOGNUM_WARPS = $clog2(GPU_NUM_WARPS);
   localparam int unsigned GPU_MAX_GREEDY   = 4;

   // Bits needed to hold a count 0..max_greedy inclusive.
   function automatic int unsigned greedy_cnt_width(input int unsigned max_greedy);
      return $clog2(max_greedy + 1);
   endfunction

endpackage

// File: rtl/issue_unit_rr_picker.sv
// rr_picker: rotating priority picker.
// Scans req starting at index start, then start+1, ... wrapping modulo N,
// and returns the first set bit.
//   req   : request vector
//   start : highest-priority index for this scan
//   grant : one-hot grant, zero when no request
//   idx   : index of the granted bit, zero when no request
//   any   : at least one request present
// N must be a power of two so the LOGN-bit index wraps naturally.
module rr_picker #(
   parameter int N    = 8,
   parameter int LOGN = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [LOGN-1:0] start,
   output logic [N-1:0]    grant,
   output logic [LOGN-1:0] idx,
   output logic            any
);

   logic [LOGN-1:0] pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = '0;
      for (int i = 0; i < N; i++) begin
         pos = start + LOGN'(i);
         if (!any && req[pos]) begin
            any        = 1'b1;
            idx        = pos;
            grant[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/issue_unit.sv
// issue_unit: warp issue and exit arbiter.
// Issue uses greedy-then-round-robin: the last issued warp keeps the grant for
// up to MAX_GREEDY consecutive issues while it keeps requesting, after which
// (or when it drops) the scan moves on starting from the warp after it.
// Exit uses a plain round-robin pointer, independent of issue and of the
// operand collector back-pressure. Grants are combinational; state updates on
// the rising clock edge.
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   Req_IB_IU      : per-warp issue request
//   Full_OC_IB     : operand collector full, blocks issue
//   Exit_Req_IB_IU : per-warp exit request
//   Grt_IU_IB      : one-hot-or-zero issue grant
//   Exit_Grt_IU_IB : one-hot-or-zero exit grant
//   Issue_WarpID_IU: index of the issued warp, 0 when no issue grant
module issue_unit
   import issue_unit_pkg::*;
#(
   parameter int NUM_WARPS    = GPU_NUM_WARPS,
   parameter int LOGNUM_WARPS = $clog2(NUM_WARPS),
   parameter int MAX_GREEDY   = GPU_MAX_GREEDY
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_WARPS-1:0]    Req_IB_IU,
   input  logic                    Full_OC_IB,
   input  logic [NUM_WARPS-1:0]    Exit_Req_IB_IU,
   output logic [NUM_WARPS-1:0]    Grt_IU_IB,
   output logic [NUM_WARPS-1:0]    Exit_Grt_IU_IB,
   output logic [LOGNUM_WARPS-1:0] Issue_WarpID_IU
);

   localparam int CNT_W = greedy_cnt_width(MAX_GREEDY);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_GREEDY);

   logic [LOGNUM_WARPS-1:0] last_warp;
   logic                    last_valid;
   logic [CNT_W-1:0]        greedy_cnt;
   logic [LOGNUM_WARPS-1:0] exit_ptr;

   logic [LOGNUM_WARPS-1:0] issue_start;
   logic [NUM_WARPS-1:0]    scan_grant;
   logic [LOGNUM_WARPS-1:0] scan_idx;
   logic                    scan_any;

   logic [NUM_WARPS-1:0]    exit_grant;
   logic [LOGNUM_WARPS-1:0] exit_idx;
   logic                    exit_any;

   logic                    greedy_hit;
   logic                    issue_ok;
   logic [NUM_WARPS-1:0]    issue_grant;
   logic [LOGNUM_WARPS-1:0] issue_idx;

   // The scan begins just past the last issued warp, so last_warp itself is
   // considered last; after reset last_warp is NUM_WARPS-1, giving warp 0.
   assign issue_start = last_warp + LOGNUM_WARPS'(1);

   rr_picker #(
      .N    (NUM_WARPS),
      .LOGN (LOGNUM_WARPS)
   ) u_issue_pick (
      .req   (Req_IB_IU),
      .start (issue_start),
      .grant (scan_grant),
      .idx   (scan_idx),
      .any   (scan_any)
   );

   rr_picker #(
      .N    (NUM_WARPS),
      .LOGN (LOGNUM_WARPS)
   ) u_exit_pick (
      .req   (Exit_Req_IB_IU),
      .start (exit_ptr),
      .grant (exit_grant),
      .idx   (exit_idx),
      .any   (exit_any)
   );

   assign greedy_hit = last_valid && Req_IB_IU[last_warp] && (greedy_cnt < MAX_CNT);
   assign issue_ok   = !Full_OC_IB && scan_any;

   always_comb begin
      issue_grant = '0;
      issue_idx   = '0;
      if (issue_ok) begin
         if (greedy_hit) begin
            issue_grant[last_warp] = 1'b1;
            issue_idx              = last_warp;
         end else begin
            issue_grant = scan_grant;
            issue_idx   = scan_idx;
         end
      end
   end

   assign Grt_IU_IB       = rst ? '0 : issue_grant;
   assign Exit_Grt_IU_IB  = rst ? '0 : exit_grant;
   assign Issue_WarpID_IU = rst ? '0 : issue_idx;

   // A grant that came from the scan (not the greedy path) always restarts
   // the burst at 1, including a re-grant of an exhausted sole requester.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_valid <= 1'b0;
         last_warp  <= LOGNUM_WARPS'(NUM_WARPS - 1);
         greedy_cnt <= '0;
         exit_ptr   <= '0;
      end else begin
         if (issue_ok) begin
            last_warp  <= issue_idx;
            last_valid <= 1'b1;
            greedy_cnt <= greedy_hit ? (greedy_cnt + CNT_W'(1)) : CNT_W'(1);
         end
         if (exit_any) begin
            exit_ptr <= exit_idx + LOGNUM_WARPS'(1);
         end
      end
   end

endmodule

// File: tb/tb_issue_unit.sv
module tb_issue_unit;

   localparam int NW = 8;
   localparam int MG = 4;

   logic          clk;
   logic          rst;
   logic [NW-1:0] req;
   logic          full;
   logic [NW-1:0] exit_req;
   logic [NW-1:0] grt;
   logic [NW-1:0] exit_grt;
   logic [2:0]    wid;

   int n_cmp = 0;
   int n_bad = 0;

   issue_unit dut (
      .clk             (clk),
      .rst             (rst),
      .Req_IB_IU       (req),
      .Full_OC_IB      (full),
      .Exit_Req_IB_IU  (exit_req),
      .Grt_IU_IB       (grt),
      .Exit_Grt_IU_IB  (exit_grt),
      .Issue_WarpID_IU (wid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst      = 1'b1;
      req      = '0;
      full     = 1'b0;
      exit_req = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst      = 1'b1;
      req      = 8'hFF;
      exit_req = 8'hFF;
      full     = 1'b0;
      tick();
      #2;
      n_cmp++; if (grt !== 8'h00) begin n_bad++; $display("FAIL rst_grt got=%h want=00", grt); end
      n_cmp++; if (exit_grt !== 8'h00) begin n_bad++; $display("FAIL rst_exit got=%h want=00", exit_grt); end
      n_cmp++; if (wid !== 3'd0) begin n_bad++; $display("FAIL rst_wid got=%0d want=0", wid); end
      tick();
      rst      = 1'b0;
      req      = 8'h82;
      exit_req = 8'h81;
      #2;
      n_cmp++; if (grt !== 8'h02) begin n_bad++; $display("FAIL post_rst_grt got=%h want=02", grt); end
      n_cmp++; if (wid !== 3'd1) begin n_bad++; $display("FAIL post_rst_wid got=%0d want=1", wid); end
      n_cmp++; if (exit_grt !== 8'h01) begin n_bad++; $display("FAIL post_rst_exit got=%h want=01", exit_grt); end
      tick();
      req      = 8'h00;
      exit_req = 8'h00;
      #2;
      n_cmp++; if (grt !== 8'h00 || wid !== 3'd0) begin n_bad++; $display("FAIL noreq grt=%h wid=%0d want=00/0", grt, wid); end
      tick();
   endtask

   task automatic test_greedy_pair;
      logic [2:0] exp_w [9];
      exp_w = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0};
      do_reset();
      req = 8'b1000_0001;
      for (int c = 0; c < 9; c++) begin
         #2;
         n_cmp++;
         if (wid !== exp_w[c] || grt !== (8'h01 << exp_w[c])) begin
            n_bad++;
            $display("FAIL greedy_pair cyc%0d got wid=%0d grt=%h want wid=%0d", c + 1, wid, grt, exp_w[c]);
         end
         tick();
      end
   endtask

   task automatic test_full_block;
      do_reset();
      req  = 8'hFF;
      full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2;
         n_cmp++; if (grt !== 8'h00) begin n_bad++; $display("FAIL full_block cyc%0d got=%h want=00", c, grt); end
         tick();
      end
      full = 1'b0;
      #2;
      n_cmp++; if (grt !== 8'h01 || wid !== 3'd0) begin n_bad++; $display("FAIL full_release got grt=%h wid=%0d want=01/0", grt, wid); end
      tick();
      n_cmp++; if (dut.greedy_cnt !== 3'd1) begin n_bad++; $display("FAIL full_release_cnt got=%0d want=1", dut.greedy_cnt); end
   endtask

   task automatic test_single_greedy;
      int exp_c [10];
      exp_c = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2};
      do_reset();
      req = 8'h08;
      for (int c = 0; c < 10; c++) begin
         #2;
         n_cmp++; if (grt !== 8'h08 || wid !== 3'd3) begin n_bad++; $display("FAIL single_grt cyc%0d got=%h want=08", c, grt); end
         tick();
         n_cmp++; if (dut.greedy_cnt !== 3'(exp_c[c])) begin n_bad++; $display("FAIL single_cnt cyc%0d got=%0d want=%0d", c, dut.greedy_cnt, exp_c[c]); end
      end
   endtask

   task automatic test_exit;
      logic [7:0] exp_e [3];
      exp_e = '{8'h04, 8'h20, 8'h04};
      do_reset();
      full     = 1'b1;
      req      = 8'hFF;
      exit_req = 8'b0010_0100;
      for (int c = 0; c < 3; c++) begin
         #2;
         n_cmp++; if (exit_grt !== exp_e[c]) begin n_bad++; $display("FAIL exit cyc%0d got=%h want=%h", c, exit_grt, exp_e[c]); end
         n_cmp++; if (grt !== 8'h00) begin n_bad++; $display("FAIL exit_issue cyc%0d got=%h want=00", c, grt); end
         tick();
      end
      full     = 1'b0;
      exit_req = 8'h00;
   endtask

   task automatic test_reset_mid_greedy;
      do_reset();
      req = 8'h10;
      tick();
      tick();
      rst = 1'b1;
      req = 8'h11;
      #2;
      n_cmp++; if (grt !== 8'h00 || wid !== 3'd0) begin n_bad++; $display("FAIL mid_rst_grt got=%h wid=%0d want=00/0", grt, wid); end
      tick();
      rst = 1'b0;
      #2;
      n_cmp++; if (grt !== 8'h01 || wid !== 3'd0) begin n_bad++; $display("FAIL after_mid_rst got=%h wid=%0d want=01/0", grt, wid); end
      tick();
   endtask

   task automatic test_drop_mid_greedy;
      do_reset();
      req = 8'h10;
      tick();
      tick();
      req = 8'h41;
      #2;
      n_cmp++; if (grt !== 8'h40 || wid !== 3'd6) begin n_bad++; $display("FAIL drop_grt got=%h wid=%0d want=40/6", grt, wid); end
      tick();
      n_cmp++; if (dut.greedy_cnt !== 3'd1) begin n_bad++; $display("FAIL drop_cnt got=%0d want=1", dut.greedy_cnt); end
      #2;
      n_cmp++; if (grt !== 8'h40) begin n_bad++; $display("FAIL drop_greedy got=%h want=40", grt); end
      tick();
   endtask

   task automatic test_same_warp_both;
      do_reset();
      req      = 8'h04;
      exit_req = 8'h04;
      #2;
      n_cmp++; if (grt !== 8'h04 || exit_grt !== 8'h04) begin n_bad++; $display("FAIL both got grt=%h exit=%h want=04/04", grt, exit_grt); end
      tick();
      req      = 8'h00;
      exit_req = 8'h00;
   endtask

   task automatic test_random;
      int         starve [NW];
      int         worst;
      logic [7:0] m;
      do_reset();
      for (int w = 0; w < NW; w++) starve[w] = 0;
      req      = 8'h5A;
      exit_req = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         m        = 8'($urandom & $urandom & $urandom);
         req      = req ^ m;
         exit_req = 8'($urandom & $urandom);
         full     = ($urandom_range(0, 3) == 0);
         #2;
         n_cmp++;
         if ((grt & (grt - 8'h01)) !== 8'h00 || (grt & ~req) !== 8'h00 || (full && grt !== 8'h00)) begin
            n_bad++;
            $display("FAIL rand_grt cyc%0d grt=%h req=%h full=%b", c, grt, req, full);
         end
         n_cmp++;
         if ((!full && req !== 8'h00) ? (grt !== (8'h01 << wid)) : (grt !== 8'h00 || wid !== 3'd0)) begin
            n_bad++;
            $display("FAIL rand_wid cyc%0d grt=%h wid=%0d", c, grt, wid);
         end
         n_cmp++;
         if ((exit_grt & (exit_grt - 8'h01)) !== 8'h00 || (exit_grt & ~exit_req) !== 8'h00 ||
             (exit_req !== 8'h00 && exit_grt === 8'h00)) begin
            n_bad++;
            $display("FAIL rand_exit cyc%0d exit_grt=%h exit_req=%h", c, exit_grt, exit_req);
         end
         worst = 0;
         for (int w = 0; w < NW; w++) begin
            if (!req[w] || grt[w]) starve[w] = 0;
            else if (grt !== 8'h00) starve[w]++;
            if (starve[w] > worst) worst = starve[w];
         end
         n_cmp++;
         if (worst > NW * MG) begin
            n_bad++;
            $display("FAIL rand_starve cyc%0d got=%0d limit=%0d", c, worst, NW * MG);
         end
         tick();
      end
      full     = 1'b0;
      req      = '0;
      exit_req = '0;
   endtask

   initial begin
      rst      = 1'b1;
      req      = '0;
      full     = 1'b0;
      exit_req = '0;
      #1;
      test_reset();
      test_greedy_pair();
      test_full_block();
      test_single_greedy();
      test_exit();
      test_reset_mid_greedy();
      test_drop_mid_greedy();
      test_same_warp_both();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
